rob_cpl_arbiter: RTL
====================

Name: rob_cpl_arbiter

Overview:
Merges completion results from multiple execution sources (ALU, MUL pipe, data cache) onto the single ROB completion write port (complete/idx/value/exception). Each source has a one-entry holding buffer with valid/ready backpressure. A round-robin arbiter picks one buffered result per cycle and drives a registered completion beat. Sits between the execute/cache stages and the reorder buffer.

Parameters:
NUM_SRC, 3, number of completion sources (0=ALU, 1=MUL, 2=cache)
IDX_W, 4, ROB index width (matches ROB alloc idx)
DATA_W, 32, result value width
EXC_W, 3, exception vector width (0 = no exception)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
in_valid  input  NUM_SRC  per-source completion request
in_idx  input  NUM_SRC*IDX_W  per-source ROB index, source i at [i*IDX_W +: IDX_W]
in_value  input  NUM_SRC*DATA_W  per-source result, packed as above
in_exception  input  NUM_SRC*EXC_W  per-source exception vector, packed as above
out_ready  output  NUM_SRC  per-source accept; a beat transfers when in_valid[i] && out_ready[i]
in_flush  input  1  ROB exception flush; discards everything pending
out_complete  output  1  one-cycle completion strobe to ROB
out_complete_idx  output  IDX_W  ROB index being completed
out_complete_value  output  DATA_W  result value
out_exception  output  EXC_W  exception vector
out_busy  output  1  any holding buffer valid

Behaviour:
- Reset: asynchronous and active-high. Clears buf_valid[*], rr_ptr=0, out_complete=0, out_complete_idx=0, out_complete_value=0, out_exception=0. out_ready = all ones once reset deasserts (buffers empty). Reset mid-operation drops all buffered results.
- Buffers: per source, buf_valid, idx, value, exc.
- Arbitration (combinational): the grant is the first i with buf_valid[i], searching from rr_ptr upward modulo NUM_SRC. At most one grant per cycle.
- out_ready[i] = !in_flush && (!buf_valid[i] || grant[i]). A granted buffer may reload in the same cycle.
- On each clock edge with no flush:
  - A granted buffer's contents are registered onto out_complete_* with out_complete=1.
  - The granted buffer is cleared unless it accepts a new beat in the same edge.
  - rr_ptr becomes (granted+1) mod NUM_SRC.
  - With no grant, out_complete=0, the data outputs hold their last values, and rr_ptr is unchanged.
- Latency: a beat accepted at edge E is completed (out_complete high) after edge E+1 at the earliest. It waits up to NUM_SRC-1 extra cycles under contention.
- Throughput: one completion per cycle. A single source streaming alone sustains 1 per cycle.
- Fairness: no source waits more than NUM_SRC-1 grants once buffered.
- Flush (in_flush high at an edge):
  - All buf_valid cleared, out_complete=0 next cycle, rr_ptr=0.
  - out_ready is low during flush, so same-cycle inputs are not accepted.
  - Flush has priority over grant.
- Exception: passed through unmodified. A nonzero exc is arbitrated like any other result.
- No index checking. Two sources targeting the same idx both complete in grant order.

Optional Feature:
Macro ROB_CPL_FIXED_PRIO_EN.
- Defined: fixed priority, lowest source index wins. rr_ptr is not implemented (no state). Starvation of higher indices is permitted.
- Undefined: round-robin as specified above.

Decomposition:
- Package rob_pkg:
  - ROB_IDX_W, EXC_W, EXC_NONE=0.
  - Source id constants SRC_ALU=0, SRC_MUL=1, SRC_CACHE=2.
  - Packed struct rob_cpl_t {idx, value, exception}, shared with the ROB.
- One sub-module, rr_arbiter: inputs req vector and rr_ptr, outputs one-hot grant and encoded grant index. Combinational. Parameterised by NUM_SRC. Honours ROB_CPL_FIXED_PRIO_EN.

Test Plan:
1. Reset asserted asynchronously mid-cycle with all three buffers full -> outputs 0 immediately, out_busy=0, no out_complete after release, out_ready=3'b111.
2. ALU alone: idx=3, value=0xDEADBEEF, exc=0 accepted at edge E -> out_complete=1, idx=3, value=0xDEADBEEF in the cycle after edge E+1, for exactly one cycle.
3. All three valid together (rr_ptr=0; idx 1/2/5) -> completions idx 1, 2, 5 on three consecutive cycles. out_ready[1] and out_ready[2] low until each is granted.
4. ALU streams every cycle while the MUL buffer holds idx=7 -> grants alternate ALU, MUL, ALU. MUL idx=7 completes within 2 cycles of buffering.
5. Cache buffer holds idx=4 and MUL buffer holds idx=6, in_flush pulsed -> no out_complete for either, out_busy=0, next accepted beat goes out normally with rr_ptr=0.
6. MUL completes idx=9 with exc=3'b010 -> out_exception=3'b010, idx=9. Repeat with ROB_CPL_FIXED_PRIO_EN and all sources valid -> source 0 is granted every cycle it is valid.

Source files
------------

// File: rtl/rob_cpl_arbiter_pkg.sv
// Shared ROB completion types, widths and source ids used by the completion
// arbiter and the reorder buffer.
package rob_pkg;
   localparam int ROB_IDX_W  = 4;
   localparam int ROB_DATA_W = 32;
   localparam int EXC_W      = 3;
   localparam logic [EXC_W-1:0] EXC_NONE = '0;

   localparam int SRC_ALU   = 0;
   localparam int SRC_MUL   = 1;
   localparam int SRC_CACHE = 2;

   typedef struct packed {
      logic [ROB_IDX_W-1:0]  idx;
      logic [ROB_DATA_W-1:0] value;
      logic [EXC_W-1:0]      exception;
   } rob_cpl_t;

   // Width of a source-select value; never narrower than one bit.
   function automatic int sel_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/rob_cpl_arbiter_if.sv
// Completion-source to ROB handshake bundle: packed per-source requests in,
// per-source ready and the single ROB completion beat out.
interface rob_cpl_arbiter_if
   import rob_pkg::*;
#(
   parameter int NUM_SRC = 3,
   parameter int IDX_W   = ROB_IDX_W,
   parameter int DATA_W  = ROB_DATA_W,
   parameter int EXC_W   = rob_pkg::EXC_W
);
   logic [NUM_SRC-1:0]        in_valid;
   logic [NUM_SRC*IDX_W-1:0]  in_idx;
   logic [NUM_SRC*DATA_W-1:0] in_value;
   logic [NUM_SRC*EXC_W-1:0]  in_exception;
   logic [NUM_SRC-1:0]        out_ready;
   logic                      in_flush;
   logic                      out_complete;
   logic [IDX_W-1:0]          out_complete_idx;
   logic [DATA_W-1:0]         out_complete_value;
   logic [EXC_W-1:0]          out_exception;
   logic                      out_busy;

   modport master (
      output in_valid, in_idx, in_value, in_exception, in_flush,
      input  out_ready, out_complete, out_complete_idx, out_complete_value,
             out_exception, out_busy
   );

   modport slave (
      input  in_valid, in_idx, in_value, in_exception, in_flush,
      output out_ready, out_complete, out_complete_idx, out_complete_value,
             out_exception, out_busy
   );
endinterface

// File: rtl/rob_cpl_arbiter_rr_arbiter.sv
// Combinational request arbiter: round-robin from rr_ptr, or fixed lowest-index
// priority when ROB_CPL_FIXED_PRIO_EN is defined (rr_ptr then ignored).
module rr_arbiter
   import rob_pkg::*;
#(
   parameter int NUM_SRC = 3,
   parameter int PTR_W   = sel_w(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [PTR_W-1:0]   rr_ptr,
   output logic [NUM_SRC-1:0] grant,
   output logic [PTR_W-1:0]   grant_idx,
   output logic               grant_valid
);
`ifdef ROB_CPL_FIXED_PRIO_EN
   logic unused_rr_ptr;
   assign unused_rr_ptr = ^rr_ptr;

   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (!grant_valid && req[i]) begin
            grant[i]    = 1'b1;
            grant_idx   = PTR_W'(i);
            grant_valid = 1'b1;
         end
      end
   end
`else
   int unsigned      cand;
   logic [PTR_W-1:0] cand_sel;

   // rr_ptr is always < NUM_SRC, so a single subtract is enough to wrap.
   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      cand        = 0;
      cand_sel    = '0;
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         cand = 32'(rr_ptr) + k;
         if (cand >= NUM_SRC) cand = cand - NUM_SRC;
         cand_sel = PTR_W'(cand);
         if (!grant_valid && req[cand_sel]) begin
            grant[cand_sel] = 1'b1;
            grant_idx       = cand_sel;
            grant_valid     = 1'b1;
         end
      end
   end
`endif
endmodule

// File: rtl/rob_cpl_arbiter.sv
// ROB completion arbiter: one-entry holding buffer per source merged onto a
// registered completion port. ROB_CPL_FIXED_PRIO_EN selects fixed priority.
module rob_cpl_arbiter
   import rob_pkg::*;
#(
   parameter int NUM_SRC = 3,
   parameter int IDX_W   = ROB_IDX_W,
   parameter int DATA_W  = ROB_DATA_W,
   parameter int EXC_W   = rob_pkg::EXC_W
) (
   input  logic             clk,
   input  logic             reset,
   rob_cpl_arbiter_if.slave bus
);
   localparam int PTR_W = sel_w(NUM_SRC);

   logic [NUM_SRC-1:0] buf_valid_q, buf_valid_d;
   logic [IDX_W-1:0]   buf_idx_q   [NUM_SRC];
   logic [IDX_W-1:0]   buf_idx_d   [NUM_SRC];
   logic [DATA_W-1:0]  buf_value_q [NUM_SRC];
   logic [DATA_W-1:0]  buf_value_d [NUM_SRC];
   logic [EXC_W-1:0]   buf_exc_q   [NUM_SRC];
   logic [EXC_W-1:0]   buf_exc_d   [NUM_SRC];

   logic               out_complete_q, out_complete_d;
   logic [IDX_W-1:0]   out_idx_q, out_idx_d;
   logic [DATA_W-1:0]  out_value_q, out_value_d;
   logic [EXC_W-1:0]   out_exc_q, out_exc_d;

   logic [NUM_SRC-1:0] grant, ready, accept;
   logic [PTR_W-1:0]   grant_idx, arb_ptr;
   logic               grant_valid;

   rr_arbiter #(.NUM_SRC(NUM_SRC), .PTR_W(PTR_W)) u_arb (
      .req         (buf_valid_q),
      .rr_ptr      (arb_ptr),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

`ifdef ROB_CPL_FIXED_PRIO_EN
   logic unused_arb;
   assign arb_ptr    = '0;
   assign unused_arb = ^{grant_idx, grant_valid};
`else
   logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (bus.in_flush)
         rr_ptr_d = '0;
      else if (grant_valid)
         rr_ptr_d = (grant_idx == PTR_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) rr_ptr_q <= '0;
      else       rr_ptr_q <= rr_ptr_d;
   end

   assign arb_ptr = rr_ptr_q;
`endif

   // A granted buffer drains this edge, so it can take a new beat at once.
   assign ready  = {NUM_SRC{!bus.in_flush}} & (~buf_valid_q | grant);
   assign accept = bus.in_valid & ready;

   always_comb begin
      buf_valid_d    = buf_valid_q;
      buf_idx_d      = buf_idx_q;
      buf_value_d    = buf_value_q;
      buf_exc_d      = buf_exc_q;
      out_complete_d = 1'b0;
      out_idx_d      = out_idx_q;
      out_value_d    = out_value_q;
      out_exc_d      = out_exc_q;
      if (bus.in_flush) begin
         buf_valid_d = '0;
      end else begin
         for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (grant[i]) begin
               out_complete_d = 1'b1;
               out_idx_d      = buf_idx_q[i];
               out_value_d    = buf_value_q[i];
               out_exc_d      = buf_exc_q[i];
               buf_valid_d[i] = 1'b0;
            end
            if (accept[i]) begin
               buf_valid_d[i] = 1'b1;
               buf_idx_d[i]   = bus.in_idx[i*IDX_W +: IDX_W];
               buf_value_d[i] = bus.in_value[i*DATA_W +: DATA_W];
               buf_exc_d[i]   = bus.in_exception[i*EXC_W +: EXC_W];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         buf_valid_q <= '0;
         for (int unsigned i = 0; i < NUM_SRC; i++) begin
            buf_idx_q[i]   <= '0;
            buf_value_q[i] <= '0;
            buf_exc_q[i]   <= '0;
         end
         out_complete_q <= 1'b0;
         out_idx_q      <= '0;
         out_value_q    <= '0;
         out_exc_q      <= '0;
      end else begin
         buf_valid_q    <= buf_valid_d;
         buf_idx_q      <= buf_idx_d;
         buf_value_q    <= buf_value_d;
         buf_exc_q      <= buf_exc_d;
         out_complete_q <= out_complete_d;
         out_idx_q      <= out_idx_d;
         out_value_q    <= out_value_d;
         out_exc_q      <= out_exc_d;
      end
   end

   assign bus.out_ready          = ready;
   assign bus.out_complete       = out_complete_q;
   assign bus.out_complete_idx   = out_idx_q;
   assign bus.out_complete_value = out_value_q;
   assign bus.out_exception      = out_exc_q;
   assign bus.out_busy           = |buf_valid_q;
endmodule
